// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes the single-wire LED stream into 24-bit words.
// Define WS2812_RX_FORWARD_EN to forward words beyond NUM_LEDS on ws_dout.
`timescale 1ns/1ps
module ws2812_rx #(
  parameter int NUM_LEDS     = 16,
  parameter int HIGH_THRESH  = 6,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 12,
  parameter int LATCH_CYCLES = 600
) (
  input  logic                        hwclk,
  input  logic                        reset_n,
  input  logic                        ws_din,
  output logic [23:0]                 rgb_data,
  output logic                        rgb_valid,
  output logic [$clog2(NUM_LEDS)-1:0] led_index,
  output logic                        frame_done,
  output logic                        bit_err,
  output logic                        ws_dout
);

  localparam int CW = $clog2(LATCH_CYCLES + 1);
  localparam int IW = $clog2(NUM_LEDS);
`ifdef WS2812_RX_FORWARD_EN
  localparam int WW = $clog2(NUM_LEDS + 1);
`else
  localparam int WW = IW;
`endif

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] C_MIN  = CW'(MIN_HIGH);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX_HIGH);
  localparam logic [CW-1:0] C_THR  = CW'(HIGH_THRESH);
  localparam logic [WW-1:0] W_LAST = WW'(NUM_LEDS - 1);
  localparam logic [WW-1:0] W_ONE  = WW'(1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t          r_state;
  logic            r_s1;
  logic            r_s2;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_bcnt;
  logic [22:0]     r_shift;
  logic [WW-1:0]   r_wcnt;
  logic [23:0]     r_data;
  logic [IW-1:0]   r_idx;
  logic            r_valid;
  logic            r_fdone;
  logic            r_err;
`ifdef WS2812_RX_FORWARD_EN
  logic            r_fwd;
  logic            r_dout;
`endif

  logic            w_din;
  logic            w_bit;
  logic [23:0]     w_word;
  logic            w_own;

  assign w_din  = r_s2;
  assign w_bit  = (r_cnt >= C_THR);
  assign w_word = {r_shift, w_bit};
`ifdef WS2812_RX_FORWARD_EN
  assign w_own  = (r_wcnt != WW'(NUM_LEDS));
`else
  assign w_own  = 1'b1;
`endif

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_wcnt  <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_fdone <= 1'b0;
      r_err   <= 1'b0;
`ifdef WS2812_RX_FORWARD_EN
      r_fwd   <= 1'b0;
      r_dout  <= 1'b0;
`endif
    end else begin
      r_s1    <= ws_din;
      r_s2    <= r_s1;
      r_valid <= 1'b0;
      r_fdone <= 1'b0;
      r_err   <= 1'b0;
`ifdef WS2812_RX_FORWARD_EN
      // Same 2-cycle latency as the synchronised input
      r_dout  <= r_fwd & r_s1;
`endif
      unique case (r_state)
        S_WAIT: begin
          if (w_din) begin
            r_cnt <= '0;
          end else if (r_cnt == C_LAST) begin
            // A full latch gap here also starts a fresh frame
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wcnt  <= '0;
`ifdef WS2812_RX_FORWARD_EN
            r_fwd   <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_IDLE: begin
          if (w_din) begin
            r_state <= S_HIGH;
            r_cnt   <= C_ONE;
          end
        end
        S_HIGH: begin
          if (w_din) begin
            if (r_cnt >= C_MAX) begin
              r_err   <= 1'b1;
              r_bcnt  <= '0;
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end else if (r_cnt < C_MIN) begin
            r_err   <= 1'b1;
            r_bcnt  <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_shift <= w_word[22:0];
            r_cnt   <= C_ONE;
            r_state <= S_LOW;
            if (r_bcnt == 5'd23) begin
              r_bcnt <= '0;
              if (w_own) begin
                r_data  <= w_word;
                r_idx   <= r_wcnt[IW-1:0];
                r_valid <= 1'b1;
`ifdef WS2812_RX_FORWARD_EN
                r_wcnt  <= r_wcnt + W_ONE;
                if (r_wcnt == W_LAST) r_fwd <= 1'b1;
`else
                r_wcnt  <= (r_wcnt == W_LAST) ? '0 : r_wcnt + W_ONE;
`endif
              end
            end else begin
              r_bcnt <= r_bcnt + 5'd1;
            end
          end
        end
        S_LOW: begin
          if (w_din) begin
            r_state <= S_HIGH;
            r_cnt   <= C_ONE;
          end else if (r_cnt == C_LAST) begin
            r_fdone <= 1'b1;
            r_err   <= (r_bcnt != 5'd0);
            r_bcnt  <= '0;
            r_wcnt  <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
`ifdef WS2812_RX_FORWARD_EN
            r_fwd   <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign rgb_data   = r_data;
  assign rgb_valid  = r_valid;
  assign led_index  = r_idx;
  assign frame_done = r_fdone;
  assign bit_err    = r_err;
`ifdef WS2812_RX_FORWARD_EN
  assign ws_dout    = r_dout;
`else
  assign ws_dout    = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: pulse-level model predicts strobes per cycle.
// Honours WS2812_RX_FORWARD_EN the same way the design does.
`timescale 1ns/1ps
module tb_ws2812_rx;

  localparam int NL   = 16;
  localparam int THR  = 6;
  localparam int MINH = 2;
  localparam int MAXH = 12;
  localparam int LAT  = 600;
  localparam int MAXC = 40000;
`ifdef WS2812_RX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        hwclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ws_din = 1'b0;
  logic [23:0] rgb_data;
  logic        rgb_valid;
  logic [3:0]  led_index;
  logic        frame_done;
  logic        bit_err;
  logic        ws_dout;

  ws2812_rx dut (
    .hwclk      (hwclk),
    .reset_n    (reset_n),
    .ws_din     (ws_din),
    .rgb_data   (rgb_data),
    .rgb_valid  (rgb_valid),
    .led_index  (led_index),
    .frame_done (frame_done),
    .bit_err    (bit_err),
    .ws_dout    (ws_dout)
  );

  always #5 hwclk = ~hwclk;

  int cyc = 0;
  always @(posedge hwclk) cyc <= cyc + 1;

  // Expected strobes indexed by the cycle they must be visible in
  bit          exp_v  [MAXC];
  bit          exp_fd [MAXC];
  bit          exp_err[MAXC];
  logic [23:0] exp_d  [MAXC];
  logic [3:0]  exp_i  [MAXC];
  bit          drv    [MAXC];
  int          fwd_from = MAXC;
  int          fwd_to   = MAXC;

  int n_chk = 0;
  int n_fail = 0;

  int          m_bits = 0;
  int          m_wc = 0;
  logic [23:0] m_word = '0;

  int          n_v = 0, n_fd = 0, n_err = 0, n_fderr = 0, n_dh = 0;
  logic [23:0] last_d = '0;
  logic [3:0]  last_i = '0;
  logic [23:0] hv_d = '0;
  logic [3:0]  hv_i = '0;
  int          ct;
  bit          e_dout;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void put_err(input int t);
    if (t < MAXC) exp_err[t] = 1'b1;
  endfunction

  // One high pulse of hi cycles starting at slot s, followed by lo low cycles
  function automatic void mdl(input int s, input int hi, input int lo);
    int f;
    f = s + hi;
    if (hi > MAXH) begin
      put_err(s + MAXH + 3);
      m_bits = 0;
      if (lo >= LAT) begin
        m_wc = 0;
        if (fwd_from < MAXC && fwd_to == MAXC) fwd_to = f + LAT + 2;
      end
      return;
    end
    if (hi < MINH) begin
      put_err(f + 3);
      m_bits = 0;
      return;
    end
    m_word = {m_word[22:0], (hi >= THR)};
    m_bits++;
    if (m_bits == 24) begin
      m_bits = 0;
      if (!(FWD && m_wc >= NL)) begin
        if (f + 3 < MAXC) begin
          exp_v[f+3] = 1'b1;
          exp_d[f+3] = m_word;
          exp_i[f+3] = 4'(m_wc % NL);
        end
        m_wc++;
        if (FWD && m_wc == NL) begin
          fwd_from = f + 4;
          fwd_to   = MAXC;
        end
      end
    end
    if (lo >= LAT) begin
      if (f + LAT + 2 < MAXC) exp_fd[f+LAT+2] = 1'b1;
      if (m_bits != 0) put_err(f + LAT + 2);
      m_bits = 0;
      m_wc = 0;
      if (fwd_from < MAXC && fwd_to == MAXC) fwd_to = f + LAT + 2;
    end
  endfunction

  task automatic slot(input bit v);
    @(posedge hwclk);
    #1;
    ws_din = v;
    if (cyc < MAXC) drv[cyc] = v;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) slot(1'b0);
  endtask

  task automatic pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) begin
      slot(1'b1);
      if (i == 0) mdl(cyc, hi, lo);
    end
    for (int i = 0; i < lo; i++) slot(1'b0);
  endtask

  task automatic send(input logic [23:0] w, input int n, input int last_lo);
    for (int i = 0; i < n; i++) begin
      int hi;
      int lo;
      hi = w[23-i] ? 8 : 4;
      lo = (i == n - 1 && last_lo > 0) ? last_lo : 15 - hi;
      pulse(hi, lo);
    end
  endtask

  always @(negedge hwclk) begin
    if (!reset_n) begin
      hv_d = '0;
      hv_i = '0;
      chk("rst_valid", 32'(rgb_valid), 32'd0);
      chk("rst_data", 32'(rgb_data), 32'd0);
      chk("rst_index", 32'(led_index), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_bit_err", 32'(bit_err), 32'd0);
      chk("rst_ws_dout", 32'(ws_dout), 32'd0);
    end else if (cyc < MAXC) begin
      ct = cyc;
      if (exp_v[ct]) begin
        hv_d = exp_d[ct];
        hv_i = exp_i[ct];
      end
      e_dout = (ct >= 2 && ct >= fwd_from && ct <= fwd_to) ? drv[ct-2] : 1'b0;
      chk("rgb_valid", 32'(rgb_valid), 32'(exp_v[ct]));
      chk("frame_done", 32'(frame_done), 32'(exp_fd[ct]));
      chk("bit_err", 32'(bit_err), 32'(exp_err[ct]));
      chk("ws_dout", 32'(ws_dout), 32'(e_dout));
      chk("rgb_data", 32'(rgb_data), 32'(hv_d));
      chk("led_index", 32'(led_index), 32'(hv_i));
      if (rgb_valid) begin
        n_v++;
        last_d = rgb_data;
        last_i = led_index;
      end
      if (frame_done) n_fd++;
      if (bit_err) n_err++;
      if (frame_done && bit_err) n_fderr++;
      if (ws_dout) n_dh++;
    end
  end

  int b_v, b_fd, b_err, b_fderr, b_dh;

  task automatic snap();
    b_v = n_v;
    b_fd = n_fd;
    b_err = n_err;
    b_fderr = n_fderr;
    b_dh = n_dh;
  endtask

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w;
    int exp_dh;
    reset_n = 1'b0;
    ws_din  = 1'b0;
    repeat (3) @(posedge hwclk);
    #1 reset_n = 1'b1;
    gap(700);

    snap();
    send(24'hFF0000, 24, 700);
    chk("t1_valid_count", 32'(n_v - b_v), 32'd1);
    chk("t1_data", 32'(last_d), 32'hFF0000);
    chk("t1_index", 32'(last_i), 32'd0);
    chk("t1_frame_done_count", 32'(n_fd - b_fd), 32'd1);
    chk("t1_bit_err_count", 32'(n_err - b_err), 32'd0);

    snap();
    for (int k = 0; k < 16; k++) send(24'h101010, 24, (k == 15) ? 700 : 0);
    chk("t2_valid_count", 32'(n_v - b_v), 32'd16);
    chk("t2_last_index", 32'(last_i), 32'd15);
    chk("t2_frame_done_count", 32'(n_fd - b_fd), 32'd1);

    snap();
    send(24'h3C3C3C, 10, 0);
    pulse(1, 10);
    send(24'hA5C33C, 24, 700);
    chk("t3_bit_err_count", 32'(n_err - b_err), 32'd1);
    chk("t3_valid_count", 32'(n_v - b_v), 32'd1);
    chk("t3_data", 32'(last_d), 32'hA5C33C);
    chk("t3_index", 32'(last_i), 32'd0);

    snap();
    send(24'hABC000, 12, 700);
    chk("t4_fd_err_same", 32'(n_fderr - b_fderr), 32'd1);
    chk("t4_valid_count", 32'(n_v - b_v), 32'd0);

    snap();
    pulse(20, 700);
    send(24'h5A0F96, 24, 700);
    chk("t5_bit_err_count", 32'(n_err - b_err), 32'd1);
    chk("t5_valid_count", 32'(n_v - b_v), 32'd1);
    chk("t5_data", 32'(last_d), 32'h5A0F96);

    snap();
    for (int k = 0; k < 18; k++) begin
      w = 24'(24'h123456 + k * 24'h010203);
      send(w, 24, (k == 17) ? 700 : 0);
    end
    chk("t6_frame_done_count", 32'(n_fd - b_fd), 32'd1);
    if (FWD) begin
      exp_dh = 0;
      for (int k = 16; k < 18; k++) begin
        w = 24'(24'h123456 + k * 24'h010203);
        exp_dh += 8 * $countones(w) + 4 * (24 - $countones(w));
      end
      chk("t6_valid_count", 32'(n_v - b_v), 32'd16);
      chk("t6_last_data", 32'(last_d), 32'h215283);
      chk("t6_last_index", 32'(last_i), 32'd15);
      chk("t6_dout_high_cycles", 32'(n_dh - b_dh), 32'(exp_dh));
    end else begin
      chk("t6_valid_count", 32'(n_v - b_v), 32'd18);
      chk("t6_last_data", 32'(last_d), 32'h235689);
      chk("t6_last_index", 32'(last_i), 32'd1);
      chk("t6_dout_high_cycles", 32'(n_dh - b_dh), 32'd0);
    end

    snap();
    send(24'hF0F0F0, 10, 0);
    @(posedge hwclk);
    #1 reset_n = 1'b0;
    m_bits = 0;
    m_wc = 0;
    gap(3);
    #1 reset_n = 1'b1;
    gap(700);
    chk("t7_data_after_reset", 32'(rgb_data), 32'd0);
    chk("t7_no_strobe", 32'(n_v - b_v + n_fd - b_fd + n_err - b_err), 32'd0);
    send(24'h0F0F0F, 24, 700);
    chk("t7_valid_count", 32'(n_v - b_v), 32'd1);
    chk("t7_data", 32'(last_d), 32'h0F0F0F);
    chk("t7_index", 32'(last_i), 32'd0);

    gap(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
